ifu: RTL and testbench

Instruction fetch unit for the single-cycle NPC core; the producer side of the `inst` interface that feeds the decoder. Holds the 64-bit PC, issues one 32-bit read at a time to instruction memory over a valid/ready request channel, and presents each fetched word with its PC to the decoder over a valid/ready channel. Accepts PC redirects from execute (branches/jumps) and discards in-flight stale fetches.

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu.sv | 104 ++++++++++
 tb/tb_ifu.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and types for the NPC core front end.
// Holds fetch-unit reset values, the NOP substitute and the fetch FSM encoding.
package ifu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 64'd4;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } ifu_state_e;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read at a
// time and hands each fetched word with its PC to the decoder.
module ifu
  import ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  ifu_state_e      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst_pc;
  logic [ILEN-1:0] r_inst;
  logic            r_inst_valid;
  logic            r_inst_err;

  logic            w_misaligned;
  logic            w_req_fire;

  // A misaligned PC never reaches memory; it is turned into a faulting NOP.
  assign w_misaligned   = pc_misaligned(r_pc);
  assign imem_req_valid = (r_state == ST_REQ) && !w_misaligned && !rst;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_err   = r_inst_err;

  // NOTE: every register lives in this one block and uses <=, so redirect
  // priority over normal sequencing is expressed only by the if/else order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= '0;
      r_inst_err   <= 1'b0;
    end else if (redirect_valid) begin
      r_pc         <= redirect_pc;
      r_inst_valid <= 1'b0;
      case (r_state)
        // An accepted request still owes a response that must be swallowed.
        ST_REQ:   r_state <= w_req_fire ? ST_DRAIN : ST_REQ;
        ST_WAIT:  r_state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
        ST_HOLD:  r_state <= ST_REQ;
        ST_DRAIN: r_state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
        default:  r_state <= ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_misaligned) begin
            r_inst       <= NOP_INST;
            r_inst_err   <= 1'b1;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_state      <= ST_HOLD;
          end else if (imem_req_ready) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            r_inst       <= imem_rsp_err ? NOP_INST : imem_rsp_data;
            r_inst_err   <= imem_rsp_err;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_pc         <= r_pc + PC_STEP;
            r_state      <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_rsp_valid) begin
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a latency-configurable memory model, a scoreboard
// of expected decoder-side instructions, and one task per scenario.
module tb_ifu;
  import ifu_pkg::*;

  logic            clk;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   hs_last  = 0;
  int   hs_prev  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents are a pure function of the address.
  function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return 32'h0010_0093 + {a[15:0], 16'h0000};
  endfunction

  function automatic exp_t mk(input logic [ILEN-1:0] i, input logic [XLEN-1:0] p, input logic e);
    exp_t x;
    x.inst = i;
    x.pc   = p;
    x.err  = e;
    return x;
  endfunction

  // Memory model: acceptance sampled mid-cycle, response after mem_lat extra cycles.
  int              mem_lat      = 0;
  logic            mem_err_en   = 1'b0;
  logic [XLEN-1:0] mem_err_addr = '0;
  logic            mem_acc      = 1'b0;
  logic            mem_rst      = 1'b1;
  logic [XLEN-1:0] mem_acc_addr = '0;
  logic            mem_pending  = 1'b0;
  int              mem_cnt      = 0;
  logic [XLEN-1:0] mem_addr     = '0;
  int              n_req        = 0;

  always @(negedge clk) begin
    mem_rst      = rst;
    mem_acc      = imem_req_valid && imem_req_ready && !rst;
    mem_acc_addr = imem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    if (mem_rst) begin
      mem_pending = 1'b0;
    end else begin
      if (mem_acc) begin
        mem_pending = 1'b1;
        mem_cnt     = mem_lat;
        mem_addr    = mem_acc_addr;
        n_req       = n_req + 1;
      end else if (mem_pending && mem_cnt > 0) begin
        mem_cnt = mem_cnt - 1;
      end
      if (mem_pending && mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = mem_err_en && (mem_addr == mem_err_addr);
        imem_rsp_data  = imem_rsp_err ? 32'hDEAD_BEEF : mem_word(mem_addr);
        mem_pending    = 1'b0;
      end
    end
  end

  // Scoreboard: every decoder handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_errors = n_errors + 1;
        $display("FAIL unexpected_inst: got inst=%h pc=%h err=%b, required no instruction",
                 inst, inst_pc, inst_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (inst !== e.inst || inst_pc !== e.pc || inst_err !== e.err) begin
          n_errors = n_errors + 1;
          $display("FAIL inst_handshake: got inst=%h pc=%h err=%b, required inst=%h pc=%h err=%b",
                   inst, inst_pc, inst_err, e.inst, e.pc, e.err);
        end
      end
      hs_prev = hs_last;
      hs_last = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (inst_valid === 1'b1) return;
      tick();
    end
    n_checks = n_checks + 1;
    n_errors = n_errors + 1;
    $display("FAIL %s: got no inst_valid within %0d cycles, required inst_valid=1", name, budget);
  endtask

  task automatic accept_one(input int budget, input string name);
    inst_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (inst_valid === 1'b1) begin
        tick();
        inst_ready = 1'b0;
        return;
      end
      tick();
    end
    inst_ready = 1'b0;
    n_checks = n_checks + 1;
    n_errors = n_errors + 1;
    $display("FAIL %s: got no handshake within %0d cycles, required one", name, budget);
  endtask

  task automatic redirect(input logic [XLEN-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    n_checks = n_checks + 1;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP_INST ||
        inst_pc !== 64'd0 || inst_err !== 1'b0 || imem_req_addr !== RESET_PC) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got req_valid=%b inst_valid=%b inst=%h pc=%h err=%b addr=%h, required 0 0 %h 0 0 %h",
               name, imem_req_valid, inst_valid, inst, inst_pc, inst_err, imem_req_addr,
               NOP_INST, RESET_PC);
    end
  endtask

  task automatic check_req(input logic [XLEN-1:0] addr, input string name);
    n_checks = n_checks + 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== addr) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got req_valid=%b addr=%h, required req_valid=1 addr=%h",
               name, imem_req_valid, imem_req_addr, addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset_values");
  endtask

  task automatic test_basic();
    sb.push_back(mk(mem_word(RESET_PC), RESET_PC, 1'b0));
    imem_req_ready = 1'b1;
    rst = 1'b0;
    #1;
    check_req(RESET_PC, "first_req_cycle1");
    tick();
    n_checks = n_checks + 1;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL wait_cycle2: got req_valid=%b inst_valid=%b, required 0 0", imem_req_valid, inst_valid);
    end
    tick();
    n_checks = n_checks + 1;
    if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== 32'h0010_0093) begin
      n_errors = n_errors + 1;
      $display("FAIL inst_valid_cycle3: got valid=%b pc=%h inst=%h, required 1 %h 00100093",
               inst_valid, inst_pc, inst, RESET_PC);
    end
    accept_one(10, "basic_accept");
    check_req(64'h8000_0004, "next_req_pc4");
  endtask

  task automatic test_hold_stall();
    logic [ILEN-1:0] i0;
    logic [XLEN-1:0] p0;
    int              n0;
    sb.push_back(mk(mem_word(64'h8000_0004), 64'h8000_0004, 1'b0));
    wait_valid(20, "stall_wait_valid");
    i0 = inst;
    p0 = inst_pc;
    n0 = n_req;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks = n_checks + 1;
      if (inst_valid !== 1'b1 || inst !== i0 || inst_pc !== p0 || imem_req_valid !== 1'b0) begin
        n_errors = n_errors + 1;
        $display("FAIL hold_stable: got valid=%b inst=%h pc=%h req=%b, required 1 %h %h 0",
                 inst_valid, inst, inst_pc, imem_req_valid, i0, p0);
      end
    end
    n_checks = n_checks + 1;
    if (n_req !== n0) begin
      n_errors = n_errors + 1;
      $display("FAIL hold_no_req: got %0d requests, required %0d", n_req, n0);
    end
    accept_one(10, "stall_accept");
  endtask

  task automatic test_redirect_wait();
    mem_lat = 1;
    tick();
    n_checks = n_checks + 1;
    if (imem_req_valid !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL in_wait: got req_valid=%b, required 0", imem_req_valid);
    end
    sb.push_back(mk(mem_word(64'h8000_0100), 64'h8000_0100, 1'b0));
    redirect(64'h8000_0100);
    tick();
    check_req(64'h8000_0100, "req_after_drain");
    accept_one(20, "redirect_wait_accept");
    mem_lat = 0;
  endtask

  task automatic test_misaligned();
    int n0;
    wait_valid(20, "misalign_pre_valid");
    redirect(64'h8000_0102);
    n0 = n_req;
    sb.push_back(mk(NOP_INST, 64'h8000_0102, 1'b1));
    for (int i = 0; i < 10 && inst_valid !== 1'b1; i++) begin
      n_checks = n_checks + 1;
      if (imem_req_valid !== 1'b0) begin
        n_errors = n_errors + 1;
        $display("FAIL misalign_no_req: got req_valid=1 addr=%h, required req_valid=0", imem_req_addr);
      end
      tick();
    end
    n_checks = n_checks + 1;
    if (inst_valid !== 1'b1 || inst_err !== 1'b1 || inst !== NOP_INST ||
        inst_pc !== 64'h8000_0102 || n_req !== n0) begin
      n_errors = n_errors + 1;
      $display("FAIL misalign_hold: got valid=%b err=%b inst=%h pc=%h reqs=%0d, required 1 1 %h 80000102 %0d",
               inst_valid, inst_err, inst, inst_pc, n_req, NOP_INST, n0);
    end
    accept_one(10, "misalign_accept");
  endtask

  task automatic test_rsp_err();
    mem_err_en   = 1'b1;
    mem_err_addr = 64'h8000_0008;
    wait_valid(20, "err_pre_valid");
    redirect(64'h8000_0008);
    sb.push_back(mk(NOP_INST, 64'h8000_0008, 1'b1));
    wait_valid(20, "err_wait_valid");
    n_checks = n_checks + 1;
    if (inst_err !== 1'b1 || inst !== NOP_INST || inst_pc !== 64'h8000_0008) begin
      n_errors = n_errors + 1;
      $display("FAIL rsp_err_hold: got err=%b inst=%h pc=%h, required 1 %h 80000008",
               inst_err, inst, inst_pc, NOP_INST);
    end
    sb.push_back(mk(mem_word(64'h8000_000C), 64'h8000_000C, 1'b0));
    accept_one(10, "err_accept");
    check_req(64'h8000_000C, "req_after_err");
    mem_err_en = 1'b0;
  endtask

  task automatic test_redirect_hold_ready();
    wait_valid(20, "rhr_pre_valid");
    sb.push_back(mk(mem_word(64'h8000_0200), 64'h8000_0200, 1'b0));
    inst_ready = 1'b1;
    redirect(64'h8000_0200);
    inst_ready = 1'b0;
    check_req(64'h8000_0200, "req_at_redirect_target");
    accept_one(20, "rhr_accept");
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      logic [XLEN-1:0] a;
      a = 64'h8000_0200 + 64'(4 * k);
      sb.push_back(mk(mem_word(a), a, 1'b0));
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    inst_ready = 1'b0;
    n_checks = n_checks + 1;
    if (sb.size() != 0 || hs_last - hs_prev != 3) begin
      n_errors = n_errors + 1;
      $display("FAIL b2b_throughput: got pending=%0d spacing=%0d, required 0 and 3",
               sb.size(), hs_last - hs_prev);
    end
  endtask

  task automatic test_reset_mid();
    wait_valid(20, "rst_mid_pre_valid");
    rst = 1'b1;
    tick();
    check_reset_values("reset_mid_values");
    rst = 1'b0;
    #1;
    check_req(RESET_PC, "req_after_mid_reset");
    sb.push_back(mk(mem_word(RESET_PC), RESET_PC, 1'b0));
    accept_one(10, "rst_mid_accept");
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect_wait();
    test_misaligned();
    test_rsp_err();
    test_redirect_hold_ready();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick();
    n_checks = n_checks + 1;
    if (sb.size() != 0) begin
      n_errors = n_errors + 1;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
